// File: rtl/dice_roller.sv
// =============================================================================
// dice_roller : LFSR dice roller (sum / advantage / disadvantage) with a
//               saturating signed modifier and target compare.
// Optional feature macro: SEED_LOAD_EN (runtime LFSR seed load port)
// Revision: 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module dice_roller #(
    parameter int                NUM_BITS  = 8,
    parameter int                SIDES     = 20,
    parameter int                SIDE_BITS = 5,
    parameter int                MAX_DICE  = 4,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter logic [LFSR_W-1:0] LFSR_MASK = 16'hB400,
    localparam int               SUM_BITS  = $clog2(MAX_DICE*SIDES+1)
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef SEED_LOAD_EN
    input  logic                       seed_ld,
    input  logic [LFSR_W-1:0]          seed_val,
`endif
    input  logic                       start,
    input  logic [2:0]                 num_dice,
    input  logic [1:0]                 mode,
    input  logic signed [NUM_BITS-1:0] mod,
    input  logic signed [NUM_BITS-1:0] target,
    output logic                       busy,
    output logic                       done,
    output logic [SUM_BITS-1:0]        roll_total,
    output logic signed [NUM_BITS-1:0] final_num,
    output logic                       hit,
    output logic                       crit,
    output logic                       fumble
);

    localparam int CNT_W = $clog2(((MAX_DICE > 2) ? MAX_DICE : 2) + 1);
    localparam int EXT_W = NUM_BITS + SUM_BITS + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(EXT_W-NUM_BITS+1){1'b0}}, {(NUM_BITS-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN =
        {{(EXT_W-NUM_BITS+1){1'b1}}, {(NUM_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAW    = 2'd1,
        S_RESOLVE = 2'd2
    } state_t;

    state_t                       state, state_nxt;
    logic [LFSR_W-1:0]            lfsr, lfsr_step, lfsr_nxt;
    logic [SIDE_BITS-1:0]         draw;
    logic [SUM_BITS-1:0]          draw_ext, acc, acc_nxt;
    logic                         accept, last_die, load, take, resolve;
    logic [CNT_W-1:0]             dice_cnt, die_idx, cnt_sel;
    logic [1:0]                   mode_q;
    logic signed [NUM_BITS-1:0]   mod_q, target_q, sat_val;
    logic signed [EXT_W-1:0]      sum_ext;
    logic                         single, hit_nxt;

    // Galois LFSR; a seed load (when present) replaces the step for that cycle
    always_comb begin
        lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : '0);
`ifdef SEED_LOAD_EN
        lfsr_nxt  = seed_ld ? ((seed_val == '0) ? SEED : seed_val) : lfsr_step;
`else
        lfsr_nxt  = lfsr_step;
`endif
    end

    assign draw     = lfsr[SIDE_BITS-1:0];
    assign draw_ext = SUM_BITS'(draw);
    assign accept   = (draw != '0) && (int'(draw) <= SIDES);
    assign last_die = (die_idx + CNT_W'(1)) == dice_cnt;

    always_comb begin
        if (mode == 2'b01 || mode == 2'b10) begin
            cnt_sel = CNT_W'(2);
        end else if (num_dice == 3'd0) begin
            cnt_sel = CNT_W'(1);
        end else if (int'(num_dice) > MAX_DICE) begin
            cnt_sel = CNT_W'(MAX_DICE);
        end else begin
            cnt_sel = CNT_W'(num_dice);
        end
    end

    // First die of an advantage/disadvantage roll loads directly
    always_comb begin
        case (mode_q)
            2'b01:   acc_nxt = (die_idx == '0 || draw_ext > acc) ? draw_ext : acc;
            2'b10:   acc_nxt = (die_idx == '0 || draw_ext < acc) ? draw_ext : acc;
            default: acc_nxt = acc + draw_ext;
        endcase
    end

    always_comb begin
        sum_ext = $signed({{(EXT_W-SUM_BITS){1'b0}}, acc})
                + $signed({{(EXT_W-NUM_BITS){mod_q[NUM_BITS-1]}}, mod_q});
        if (sum_ext > SAT_MAX) begin
            sat_val = SAT_MAX[NUM_BITS-1:0];
        end else if (sum_ext < SAT_MIN) begin
            sat_val = SAT_MIN[NUM_BITS-1:0];
        end else begin
            sat_val = sum_ext[NUM_BITS-1:0];
        end
        hit_nxt = sat_val >= target_q;
        single  = (mode_q != 2'b00) || (dice_cnt == CNT_W'(1));
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        take      = 1'b0;
        resolve   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_DRAW;
                end
            end
            S_DRAW: begin
                take = accept;
                if (accept && last_die) begin
                    state_nxt = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                resolve   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr       <= SEED;
            busy       <= 1'b0;
            done       <= 1'b0;
            roll_total <= '0;
            final_num  <= '0;
            hit        <= 1'b0;
            crit       <= 1'b0;
            fumble     <= 1'b0;
            dice_cnt   <= '0;
            die_idx    <= '0;
            mode_q     <= 2'b00;
            mod_q      <= '0;
            target_q   <= '0;
            acc        <= '0;
        end else begin
            lfsr <= lfsr_nxt;
            done <= 1'b0;
            if (load) begin
                dice_cnt <= cnt_sel;
                mode_q   <= (mode == 2'b11) ? 2'b00 : mode;
                mod_q    <= mod;
                target_q <= target;
                acc      <= '0;
                die_idx  <= '0;
                busy     <= 1'b1;
            end
            if (take) begin
                acc     <= acc_nxt;
                die_idx <= die_idx + CNT_W'(1);
            end
            if (resolve) begin
                busy       <= 1'b0;
                done       <= 1'b1;
                roll_total <= acc;
                final_num  <= sat_val;
                hit        <= hit_nxt;
                crit       <= single && (acc == SUM_BITS'(SIDES));
                fumble     <= single && (acc == SUM_BITS'(1));
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dice_roller.sv
// =============================================================================
// tb_dice_roller : scoreboard bench for dice_roller with a golden LFSR model.
// Revision: 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dice_roller;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] MASK = 16'hB400;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [2:0]        num_dice = 3'd0;
    logic [1:0]        mode = 2'd0;
    logic signed [7:0] mod = 8'sd0;
    logic signed [7:0] target = 8'sd0;
    logic              busy, done, hit, crit, fumble;
    logic [6:0]        roll_total;
    logic signed [7:0] final_num;
`ifdef SEED_LOAD_EN
    logic              seed_ld = 1'b0;
    logic [15:0]       seed_val = 16'h0;
`endif

    dice_roller dut (
        .clk        (clk),
        .reset      (reset),
`ifdef SEED_LOAD_EN
        .seed_ld    (seed_ld),
        .seed_val   (seed_val),
`endif
        .start      (start),
        .num_dice   (num_dice),
        .mode       (mode),
        .mod        (mod),
        .target     (target),
        .busy       (busy),
        .done       (done),
        .roll_total (roll_total),
        .final_num  (final_num),
        .hit        (hit),
        .crit       (crit),
        .fumble     (fumble)
    );

    always #5 clk = ~clk;

    typedef struct {
        int total;
        int fin;
        int hit;
        int crit;
        int fumble;
        int lat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_lfsr;
    int          n_total = 0;
    int          n_bad   = 0;
    int          n_done  = 0;

    function automatic logic [15:0] step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? MASK : 16'h0);
    endfunction

    always @(posedge clk) begin
        if (!reset) m_lfsr <= SEED;
`ifdef SEED_LOAD_EN
        else if (seed_ld) m_lfsr <= (seed_val == 16'h0) ? SEED : seed_val;
`endif
        else m_lfsr <= step(m_lfsr);
    end

    always @(negedge clk) if (done) n_done++;

    task automatic check_val(input string tag, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // v is the LFSR value seen during the first DRAW cycle
    function automatic exp_t predict(input logic [15:0] v, input int nd, input int md,
                                     input int mo, input int tg);
        exp_t e;
        int cnt, m, acc, got, cyc, d, f;
        logic [15:0] s;
        s   = v;
        cnt = (md == 1 || md == 2) ? 2 : (nd == 0 ? 1 : (nd > 4 ? 4 : nd));
        m   = (md == 3) ? 0 : md;
        acc = 0; got = 0; cyc = 0;
        while (got < cnt) begin
            d = int'(s[4:0]);
            cyc++;
            if (d >= 1 && d <= 20) begin
                if (m == 0)        acc = acc + d;
                else if (got == 0) acc = d;
                else if (m == 1)   acc = (d > acc) ? d : acc;
                else               acc = (d < acc) ? d : acc;
                got++;
            end
            s = step(s);
        end
        f = acc + mo;
        if (f > 127)  f = 127;
        if (f < -128) f = -128;
        e.total  = acc;
        e.fin    = f;
        e.hit    = (f >= tg) ? 1 : 0;
        e.crit   = ((m != 0 || cnt == 1) && acc == 20) ? 1 : 0;
        e.fumble = ((m != 0 || cnt == 1) && acc == 1) ? 1 : 0;
        e.lat    = cyc + 1;
        return e;
    endfunction

    task automatic do_roll(input int nd, input int md, input int mo, input int tg,
                           input bit hold);
        exp_t e;
        int   k;
        @(negedge clk);
        start    = 1'b1;
        num_dice = nd[2:0];
        mode     = md[1:0];
        mod      = mo[7:0];
        target   = tg[7:0];
        @(posedge clk); #1;
        sb.push_back(predict(m_lfsr, nd, md, mo, tg));
        if (!hold) start = 1'b0;
        check_val("busy_rise", busy, 1);
        k = 0;
        while (!done && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        e = sb.pop_front();
        if (!done) begin
            check_val("done_timeout", 0, 1);
            return;
        end
        check_val("latency", k, e.lat);
        check_val("roll_total", roll_total, e.total);
        check_val("final_num", final_num, e.fin);
        check_val("hit", hit, e.hit);
        check_val("crit", crit, e.crit);
        check_val("fumble", fumble, e.fumble);
        check_val("busy_fall", busy, 0);
        if (!hold) begin
            @(posedge clk); #1;
            check_val("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_total", roll_total, 0);
        check_val("rst_final", final_num, 0);
        check_val("rst_hit", hit, 0);
        check_val("rst_crit", crit, 0);
        check_val("rst_fumble", fumble, 0);
        for (int i = 0; i < 4; i++) begin
            check_val("lfsr_seq", dut.lfsr, m_lfsr);
            @(posedge clk); #1;
        end

        do_roll(1, 0, 0, 11, 1'b0);
        do_roll(0, 0, 0, 11, 1'b0);
        do_roll(7, 0, 5, 40, 1'b0);
        do_roll(4, 3, -2, 30, 1'b0);
        do_roll(2, 1, -3, 10, 1'b0);
        do_roll(3, 2, -3, 10, 1'b0);
        do_roll(1, 0, 127, 127, 1'b0);
        do_roll(4, 0, 127, 127, 1'b0);
        do_roll(1, 0, -128, -127, 1'b0);
        do_roll(1, 2, -128, -128, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_roll(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                    1'b0);
        end

        // start held high: back-to-back rolls, starts during busy ignored
        do_roll(2, 0, 1, 20, 1'b1);
        do_roll(1, 1, 0, 15, 1'b1);
        start = 1'b0;
        @(posedge clk); #1;
        check_val("b2b_idle", busy, 0);

        // reset mid-roll with extra start pulses while busy
        @(negedge clk);
        start = 1'b1; num_dice = 3'd4; mode = 2'd0;
        @(negedge clk) start = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) begin start = 1'b0; reset = 1'b0; end
        d0 = n_done;
        @(posedge clk); #1;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_total", roll_total, 0);
        check_val("mid_rst_final", final_num, 0);
        check_val("mid_rst_lfsr", dut.lfsr, SEED);
        @(negedge clk) reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_val("mid_rst_no_done", n_done, d0);
        check_val("mid_rst_idle", busy, 0);
        do_roll(2, 0, 0, 10, 1'b0);

`ifdef SEED_LOAD_EN
        @(negedge clk) begin seed_ld = 1'b1; seed_val = 16'h0; end
        @(posedge clk); #1;
        check_val("seed_zero", dut.lfsr, SEED);
        @(negedge clk) seed_val = 16'h1234;
        @(posedge clk); #1;
        check_val("seed_val", dut.lfsr, 16'h1234);
        @(negedge clk) seed_ld = 1'b0;
        do_roll(3, 0, 0, 30, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
